// File: rtl/store_size_unit.sv
// store_size_unit
//   Commits sw/sh/sb stores to a byte-addressed, word-wide data memory.
//   - Word stores write B_out directly.
//   - Halfword and byte stores read the containing word, merge the new lanes
//     into it, and write it back.
//   Lanes are little-endian: lane k = bits [8k+7:8k].
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      one-cycle request, sampled only in IDLE
//   size       00 word, 01 halfword, 10 byte, 11 illegal
//   addr       byte address
//   B_out      register data to store
//   mem_rdata  memory read data, valid READ_LAT cycles after the address
//   mem_addr   word-aligned memory address
//   mem_wdata  merged write word
//   mem_wr     write strobe, one cycle per committed store
//   busy       high outside IDLE
//   done       one-cycle completion pulse
//   err        qualifies done: store rejected, nothing written
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; outputs hold their last values
// S_READ  | reading the containing word, counter runs 0..READ_LAT
// S_WRITE | mem_wr and done asserted for one cycle
// S_ERR   | misaligned or illegal size; done and err for one cycle

module store_size_unit #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] B_out,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] LAT_TC  = 2'(READ_LAT);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q;
  logic [1:0]  lane_q;
  logic        half_q;
  logic [15:0] bdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        start_err;
  logic [31:0] merged;

  always_comb begin
    start_err = 1'b0;
    case (size)
      SZ_WORD: start_err = (addr[1:0] != 2'b00);
      SZ_HALF: start_err = addr[0];
      SZ_BYTE: start_err = 1'b0;
      default: start_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_err)             state_d = S_ERR;
          else if (size == SZ_WORD)  state_d = S_WRITE;
          else                       state_d = S_READ;
        end
      end
      S_READ:  if (cnt_q == LAT_TC) state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lanes are replaced using only values registered at start, so the merge
  // never depends on addr/B_out once the store is under way.
  always_comb begin
    merged = mem_rdata;
    if (half_q) begin
      if (lane_q[1]) merged[31:16] = bdata_q;
      else           merged[15:0]  = bdata_q;
    end else begin
      merged[{lane_q, 3'b000} +: 8] = bdata_q[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      lane_q      <= 2'd0;
      half_q      <= 1'b0;
      bdata_q     <= 16'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          cnt_q <= 2'd0;
          if (start && !start_err) begin
            lane_q     <= addr[1:0];
            half_q     <= (size == SZ_HALF);
            bdata_q    <= B_out[15:0];
            mem_addr_q <= {addr[31:2], 2'b00};
            if (size == SZ_WORD) mem_wdata_q <= B_out;
          end
        end
        S_READ: begin
          if (cnt_q == LAT_TC) begin
            mem_wdata_q <= merged;
            cnt_q       <= 2'd0;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end

  // Strobes decode from state only, so an async reset drops them at once.
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = (state_q == S_WRITE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_WRITE) || (state_q == S_ERR);
  assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_store_size_unit.sv
// tb_store_size_unit
//   Directed checks of store_size_unit against a small word-wide memory
//   model with a READ_LAT-deep read pipeline.

module tb_store_size_unit;

  localparam int READ_LAT = 1;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] B_out;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_pipe [READ_LAT];

  store_size_unit #(.READ_LAT(READ_LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .size      (size),
    .addr      (addr),
    .B_out     (B_out),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    rd_pipe[0] <= mem_rd(mem_addr);
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_wr === 1'b1) begin
      mem[mem_addr] = mem_wdata;
      wr_count++;
    end
  end
  assign mem_rdata = rd_pipe[READ_LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; asserts start for exactly one rising edge.
  task automatic do_start(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    size  = sz;
    addr  = a;
    B_out = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at a negedge in the first IDLE
  // cycle after done, so consecutive calls are back-to-back.
  task automatic run_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] b, input logic exp_err,
                           input logic [31:0] exp_wdata, input int exp_lat);
    int n;
    int w0;
    w0 = wr_count;
    do_start(sz, a, b);
    n = 1;
    chk({tag, "_busy1"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    if (!exp_err) begin
      chk({tag, "_wr"}, 32'(mem_wr), 32'd1);
      chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
      chk({tag, "_wdata"}, mem_wdata, exp_wdata);
    end
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_nwr"}, 32'(wr_count - w0), exp_err ? 32'd0 : 32'd1);
  endtask

  initial begin
    int n;
    int w0;
    reset_n = 1'b0;
    start   = 1'b0;
    size    = 2'b00;
    addr    = 32'd0;
    B_out   = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_flags", {28'd0, mem_wr, busy, done, err}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_store("word", 2'b00, 32'h100, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1);
    chk("word_mem", mem_rd(32'h100), 32'hDEADBEEF);

    mem[32'h200] = 32'h11223344;
    run_store("byte2", 2'b10, 32'h202, 32'h000000AB, 1'b0, 32'h11AB3344, 2 + READ_LAT);
    run_store("byte0", 2'b10, 32'h200, 32'h000000CD, 1'b0, 32'h11AB33CD, 2 + READ_LAT);
    run_store("byte3", 2'b10, 32'h203, 32'hFFFFFF5A, 1'b0, 32'h5AAB33CD, 2 + READ_LAT);

    mem[32'h300] = 32'hAAAAAAAA;
    run_store("half_hi", 2'b01, 32'h302, 32'hFFFF1234, 1'b0, 32'h1234AAAA, 2 + READ_LAT);
    mem[32'h300] = 32'hAAAAAAAA;
    run_store("half_lo", 2'b01, 32'h300, 32'hFFFF1234, 1'b0, 32'hAAAA1234, 2 + READ_LAT);

    run_store("err_word", 2'b00, 32'h101, 32'h12345678, 1'b1, 32'h0, 1);
    run_store("err_half", 2'b01, 32'h103, 32'h12345678, 1'b1, 32'h0, 1);
    run_store("err_size", 2'b11, 32'h100, 32'h12345678, 1'b1, 32'h0, 1);
    chk("err_mem_intact", mem_rd(32'h100), 32'hDEADBEEF);

    // start pulsed during READ and inputs changed mid-operation
    mem[32'h200] = 32'h11223344;
    w0 = wr_count;
    do_start(2'b10, 32'h201, 32'h00000055);
    do_start(2'b00, 32'h300, 32'hFFFFFFFF);
    n = 2;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_lat", 32'(n), 32'(2 + READ_LAT));
    chk("mid_addr", mem_addr, 32'h200);
    chk("mid_wdata", mem_wdata, 32'h11225544);
    @(negedge clk);
    chk("mid_idle1", 32'(busy), 32'd0);
    @(negedge clk);
    chk("mid_idle2", 32'(busy), 32'd0);
    chk("mid_nwr", 32'(wr_count - w0), 32'd1);
    chk("mid_mem300", mem_rd(32'h300), 32'hAAAA1234);

    // reset during READ
    mem[32'h200] = 32'h11223344;
    w0 = wr_count;
    do_start(2'b10, 32'h200, 32'h00000077);
    chk("rr_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rr_flags", {28'd0, mem_wr, busy, done, err}, 32'd0);
    chk("rr_mem_addr", mem_addr, 32'd0);
    chk("rr_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rr_nwr", 32'(wr_count - w0), 32'd0);
    chk("rr_mem", mem_rd(32'h200), 32'h11223344);
    run_store("rr_byte", 2'b10, 32'h203, 32'h000000CD, 1'b0, 32'hCD223344, 2 + READ_LAT);
    chk("rr_byte_mem", mem_rd(32'h200), 32'hCD223344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_size_unit.md
# store_size_unit

Store-path counterpart to the register write-back selection: takes register B data plus an effective address from the multicycle datapath and commits `sw`, `sh` or `sb` to the byte-addressed data memory. Word stores write directly. Halfword and byte stores do a read-modify-write of the containing word. The control FSM starts it with a one-cycle `start` and waits for `done`.

## Interface
- `READ_LAT`, default 1: cycles from the first cycle an address is presented with `mem_wr`=0 until `mem_rdata` is valid; legal range 1..3.
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `size`  in  2  00 = word, 01 = halfword, 10 = byte, 11 = illegal
- `addr`  in  32  byte address (ALU_out)
- `B_out`  in  32  register data to store
- `mem_rdata`  in  32  memory read data
- `mem_addr`  out  32  word-aligned memory address
- `mem_wdata`  out  32  merged write word
- `mem_wr`  out  1  write strobe, exactly one cycle per successful store
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  qualifies `done`: 1 = store rejected, nothing written

## Operation
- Little-endian lanes: lane k = bits [8k+7:8k], selected by `addr[1:0]`.
- In IDLE, `start`=1 registers `addr`, `size` and `B_out`.
  - Later changes to these inputs have no effect on the operation in progress.
- Alignment check at start:
  - word needs `addr[1:0]`=00;
  - halfword needs `addr[0]`=0;
  - byte is always aligned;
  - `size`=11 is always an error.
- States:
  - IDLE: misaligned or illegal -> ERR; word -> WRITE; halfword or byte -> READ.
  - READ: `mem_addr`={addr[31:2],2'b00}, `mem_wr`=0. A counter runs 0..READ_LAT. At count READ_LAT, `mem_rdata` is captured and the FSM goes to WRITE.
  - WRITE: `mem_wr`=1 and `done`=1 for this cycle, then IDLE.
  - ERR: `done`=1 and `err`=1 for one cycle, `mem_wr`=0, then IDLE.
- Merge rules:
  - Word: `mem_wdata` = B_out.
  - Halfword: the captured word with lanes {2h+1, 2h} replaced by B_out[15:0], where h = addr[1].
  - Byte: the captured word with lane addr[1:0] replaced by B_out[7:0].
- `mem_addr` holds the aligned address from READ through WRITE. In IDLE it holds the last value.
- `start` while `busy`=1 is ignored and not queued.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0.
  - `mem_addr`, `mem_wdata` and captured data are 0.
  - `mem_wr`, `busy`, `done` and `err` are 0.
- Reset asserted mid-operation: `mem_wr` drops immediately and no partial write is committed.
- Start sampled at edge T:
  - word: WRITE in cycle T+1;
  - halfword/byte: READ in cycles T+1..T+1+READ_LAT, WRITE in cycle T+2+READ_LAT;
  - error: ERR in cycle T+1.
- `busy` rises in cycle T+1 and falls the cycle after `done`.
- Back-to-back: `start` may be asserted in the first IDLE cycle after `done`.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Test plan
- Word store: `addr`=0x100, `B_out`=0xDEADBEEF, `size`=00 -> one cycle later `mem_wr`=1, `mem_addr`=0x100, `mem_wdata`=0xDEADBEEF, `done`=1, `err`=0; no READ cycles.
- Byte store, READ_LAT=1: memory word at 0x200 = 0x11223344, `addr`=0x202, `B_out`=0x000000AB -> READ for 2 cycles, then `mem_wdata`=0x11AB3344 with `mem_wr`=1 at T+3.
- Halfword store: memory word at 0x300 = 0xAAAAAAAA, `addr`=0x302, `B_out`=0xFFFF1234 -> `mem_wdata`=0x1234AAAA. Repeat with `addr`=0x300 -> `mem_wdata`=0xAAAA1234.
- Misaligned or illegal, one start per case:
  - word at 0x101;
  - halfword at 0x103;
  - `size`=11.
  - Required for each case: `done`=1 with `err`=1 at T+1, and `mem_wr` never asserted.
- `start` pulsed during READ, and `addr`/`B_out` changed mid-operation -> exactly one write, using the values sampled at start.
- `reset_n` pulled low during READ -> all outputs 0 immediately, no `mem_wr`. After release, a fresh byte store completes normally.
